// File: rtl/register_file_pkg.sv
// Shared processor constants: register-file geometry and opcode encodings.
package register_file_pkg;

  localparam int unsigned RF_WIDTH    = 8;
  localparam int unsigned RF_DEPTH    = 8;
  localparam int unsigned RF_ADDR_W   = $clog2(RF_DEPTH);
  localparam int unsigned RF_ZERO_REG = 0;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_LOAD  = 4'h5,
    OP_STORE = 4'h6,
    OP_BEQ   = 4'h7
  } opcode_t;

endpackage

// File: rtl/register_w.sv
// WIDTH-bit load-enabled register built from per-bit D flip-flops with async active-low clear.
module register_w #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic q_bit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_bit <= 1'b0;
      end else if (load) begin
        q_bit <= d[b];
      end
    end

    assign q[b] = q_bit;
  end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with hardwired zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned DEPTH = RF_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST_,
  input  logic                 WE,
  input  logic [RF_ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]     WD,
  input  logic [RF_ADDR_W-1:0] RA1,
  input  logic [RF_ADDR_W-1:0] RA2,
  output logic [WIDTH-1:0]     RD1,
  output logic [WIDTH-1:0]     RD2
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd1_sel;
  logic [WIDTH-1:0] rd2_sel;

  assign regs[RF_ZERO_REG] = '0;

  // Write-address decode: one load enable per physical register (index 0 has none).
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic load;

    assign load = WE && (WA == RF_ADDR_W'(i));

    register_w #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (CLK),
      .rst_n(RST_),
      .load (load),
      .d    (WD),
      .q    (regs[i])
    );
  end

  always_comb begin
    rd1_sel = regs[RA1];
    rd2_sel = regs[RA2];
`ifdef REGFILE_BYPASS_EN
    if (WE && (WA != RF_ADDR_W'(RF_ZERO_REG)) && (RA1 == WA)) begin
      rd1_sel = WD;
    end
    if (WE && (WA != RF_ADDR_W'(RF_ZERO_REG)) && (RA2 == WA)) begin
      rd2_sel = WD;
    end
`endif
  end

  // Reset forces zero on both ports, including any bypassed write data.
  assign RD1 = RST_ ? rd1_sel : '0;
  assign RD2 = RST_ ? rd2_sel : '0;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_register_file;

  logic       CLK;
  logic       RST_;
  logic       WE;
  logic [2:0] WA;
  logic [7:0] WD;
  logic [2:0] RA1;
  logic [2:0] RA2;
  logic [7:0] RD1;
  logic [7:0] RD2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] model [8];

  register_file dut (
    .CLK (CLK),
    .RST_(RST_),
    .WE  (WE),
    .WA  (WA),
    .WD  (WD),
    .RA1 (RA1),
    .RA2 (RA2),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Spec-level read rule: address 0 is zero; same-cycle bypass only when enabled.
  function automatic logic [7:0] model_read(input logic [2:0] ra, input logic we,
                                            input logic [2:0] wa, input logic [7:0] wd);
    if (ra == 3'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 3'd0 && ra == wa) return wd;
`endif
    return model[ra];
  endfunction

  initial begin
    logic [7:0] exp_byp;

    RST_ = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;
    #3 RST_ = 1'b0;
    #4 RST_ = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) begin
      RA1 = 3'(a); RA2 = 3'(7 - a);
      #1;
      check($sformatf("post_reset_rd1[%0d]", a), RD1, 8'h00);
      check($sformatf("post_reset_rd2[%0d]", 7 - a), RD2, 8'h00);
    end

    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd7, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 3'd7, 8'hC3, 3'd5, 3'd7, 8'h3C, 8'hC3};
    vecs[4] = '{1'b0, 3'd7, 8'h00, 3'd7, 3'd7, 8'hC3, 8'hC3};
    vecs[5] = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd3, 8'h11, 8'hA5};
    vecs[6] = '{1'b0, 3'd3, 8'hFF, 3'd3, 3'd0, 8'hA5, 8'h00};

    foreach (vecs[i]) begin
      WE = vecs[i].we; WA = vecs[i].wa; WD = vecs[i].wd;
      tick();
      WE = 1'b0; RA1 = vecs[i].ra1; RA2 = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i), RD1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), RD2, vecs[i].exp2);
    end

    // Same-cycle read of the address being written.
    WE = 1'b1; WA = 3'd2; WD = 8'h22; RA1 = 3'd2; RA2 = 3'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 8'h22;
`else
    exp_byp = 8'h11;
`endif
    check("same_cycle_rd1", RD1, exp_byp);
    check("same_cycle_rd2_other", RD2, 8'hA5);
    tick();
    WE = 1'b0;
    #1;
    check("after_edge_rd1", RD1, 8'h22);

    // Reset asserted across an edge carrying a write.
    WE = 1'b1; WA = 3'd6; WD = 8'h5A; RA1 = 3'd6; RA2 = 3'd6;
    #1 RST_ = 1'b0;
    #1;
    check("rst_write_rd1_during", RD1, 8'h00);
    check("rst_write_rd2_during", RD2, 8'h00);
    @(posedge CLK);
    #2;
    WE = 1'b0;
    RST_ = 1'b1;
    #1;
    check("rst_write_rd1_after", RD1, 8'h00);
    RA2 = 3'd3;
    #1;
    check("rst_cleared_reg3", RD2, 8'h00);

    // First edge after release must accept a write.
    WE = 1'b1; WA = 3'd1; WD = 8'h77;
    tick();
    WE = 1'b0; RA1 = 3'd1;
    #1;
    check("first_write_after_rst", RD1, 8'h77);

    foreach (model[i]) model[i] = 8'h00;
    model[1] = 8'h77;

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      WE  = 1'($urandom_range(0, 1));
      WA  = 3'($urandom_range(0, 7));
      WD  = 8'($urandom);
      RA1 = 3'($urandom_range(0, 7));
      RA2 = (n % 4 == 0) ? WA : 3'($urandom_range(0, 7));
      #1;
      check($sformatf("rand%0d_rd1", n), RD1, model_read(RA1, WE, WA, WD));
      check($sformatf("rand%0d_rd2", n), RD2, model_read(RA2, WE, WA, WD));
      @(posedge CLK);
      if (WE && WA != 3'd0) model[WA] = WD;
      #1;
    end

    // Mid-cycle reset pulse: every address reads zero with no clock edge.
    WE = 1'b1; WA = 3'd4; WD = 8'h99;
    #2 RST_ = 1'b0;
    for (int a = 0; a < 8; a++) begin
      RA1 = 3'(a); RA2 = 3'(7 - a);
      #0.1;
      check($sformatf("mid_rst_rd1[%0d]", a), RD1, 8'h00);
      check($sformatf("mid_rst_rd2[%0d]", 7 - a), RD2, 8'h00);
    end
    WE = 1'b0;
    RST_ = 1'b1;
    foreach (model[i]) model[i] = 8'h00;
    for (int a = 0; a < 8; a++) begin
      RA1 = 3'(a);
      #0.1;
      check($sformatf("post_pulse_rd1[%0d]", a), RD1, model_read(RA1, 1'b0, 3'd0, 8'h00));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
